// File: rtl/riscv_pkg.sv
// Shared RV32I encoder types: format codes, opcodes, loader FSM states and the field bundle.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned FMT_W  = 3;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;

  localparam logic [FMT_W-1:0] FMT_R = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J = 3'd5;

  localparam logic [OPC_W-1:0] OP     = 7'h33;
  localparam logic [OPC_W-1:0] OP_IMM = 7'h13;
  localparam logic [OPC_W-1:0] LOAD   = 7'h03;
  localparam logic [OPC_W-1:0] STORE  = 7'h23;
  localparam logic [OPC_W-1:0] BRANCH = 7'h63;
  localparam logic [OPC_W-1:0] LUI    = 7'h37;
  localparam logic [OPC_W-1:0] JAL    = 7'h6F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic [FMT_W-1:0] fmt;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [F3_W-1:0]  funct3;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [F7_W-1:0]  funct7;
    logic [XLEN-1:0]  imm;
  } instr_fields_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input handshake plus the IMEM write port of the instruction encoder.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [2:0]        in_funct3;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // Encoder side: consumes bundles, drives the memory write port.
  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2,
           in_funct7, in_imm, in_last, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  // Loader/memory side.
  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2,
           in_funct7, in_imm, in_last, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I packer: fields + format -> instruction word, illegal-format and
// immediate-range flags. Range checking exists only when IMM_RANGE_CHECK_EN is defined.
module instr_pack
  import riscv_pkg::*;
(
  input  instr_fields_t   fields_i,
  output logic [XLEN-1:0] instr_c_o,
  output logic            illegal_c_o,
  output logic            range_err_c_o
);

  logic [XLEN-1:0] imm;
  assign imm = fields_i.imm;

  always_comb begin
    instr_c_o   = '0;
    illegal_c_o = 1'b0;
    case (fields_i.fmt)
      FMT_R: instr_c_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3,
                          fields_i.rd, fields_i.opcode};
      FMT_I: instr_c_o = {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd,
                          fields_i.opcode};
      FMT_S: instr_c_o = {imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                          imm[4:0], fields_i.opcode};
      FMT_B: instr_c_o = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                          imm[4:1], imm[11], fields_i.opcode};
      FMT_U: instr_c_o = {imm[31:12], fields_i.rd, fields_i.opcode};
      FMT_J: instr_c_o = {imm[20], imm[10:1], imm[11], imm[19:12], fields_i.rd,
                          fields_i.opcode};
      default: illegal_c_o = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // A slice is representable when it is a pure sign extension (all ones or all zeros).
  always_comb begin
    range_err_c_o = 1'b0;
    case (fields_i.fmt)
      FMT_I, FMT_S: range_err_c_o = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        range_err_c_o = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FMT_J:        range_err_c_o = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      FMT_U:        range_err_c_o = |imm[11:0];
      default:      range_err_c_o = 1'b0;
    endcase
  end
`else
  assign range_err_c_o = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder / IMEM loader: accepts field bundles, writes packed words sequentially.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  instr_encoder_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              in_ready_q, we_q, busy_q, done_q;

  instr_fields_t     fields_c;
  logic [XLEN-1:0]   instr_c;
  logic              illegal_c;
  logic              range_err_c;

  always_comb begin
    fields_c.fmt    = bus.in_fmt;
    fields_c.opcode = bus.in_opcode;
    fields_c.rd     = bus.in_rd;
    fields_c.funct3 = bus.in_funct3;
    fields_c.rs1    = bus.in_rs1;
    fields_c.rs2    = bus.in_rs2;
    fields_c.funct7 = bus.in_funct7;
    fields_c.imm    = bus.in_imm;
  end

  instr_pack u_pack (
    .fields_i      (fields_c),
    .instr_c_o     (instr_c),
    .illegal_c_o   (illegal_c),
    .range_err_c_o (range_err_c)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ACCEPT;
          addr_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      ACCEPT: begin
        if (bus.in_valid && in_ready_q) begin
          if (illegal_c || range_err_c) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            wdata_d = instr_c;
            last_d  = bus.in_last;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (we_q && bus.imem_ready) begin
          count_d = count_q + CNT_ONE;
          addr_d  = addr_q + ADDR_ONE;
          // Filling the last word without seeing in_last means the program overflowed IMEM.
          if (last_q || (addr_q == LAST_ADDR)) begin
            state_d = DONE;
            if (!last_q) err_d = 1'b1;
          end else begin
            state_d = ACCEPT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      wdata_q    <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      err_q      <= err_d;
      in_ready_q <= (state_d == ACCEPT);
      we_q       <= (state_d == WRITE);
      busy_q     <= (state_d == ACCEPT) || (state_d == WRITE);
      done_q     <= (state_d == DONE);
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign count          = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a DEPTH=1024 instance and a DEPTH=4 instance share one stimulus bundle.
module tb_instr_encoder;
  import riscv_pkg::*;

  logic clk;
  logic rst_n;
  logic start0, start1;
  logic valid0, valid1;
  logic [2:0]  f_fmt;
  logic [6:0]  f_op;
  logic [4:0]  f_rd, f_rs1, f_rs2;
  logic [2:0]  f_f3;
  logic [6:0]  f_f7;
  logic [31:0] f_imm;
  logic        f_last;
  logic        mem_ready;

  logic        busy0, done0, err0, busy1, done1, err1;
  logic [10:0] count0, count1;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  instr_encoder_if #(.ADDR_W(10)) bus0 ();
  instr_encoder_if #(.ADDR_W(10)) bus1 ();

  assign bus0.in_valid = valid0;  assign bus1.in_valid = valid1;
  assign bus0.in_fmt = f_fmt;     assign bus1.in_fmt = f_fmt;
  assign bus0.in_opcode = f_op;   assign bus1.in_opcode = f_op;
  assign bus0.in_rd = f_rd;       assign bus1.in_rd = f_rd;
  assign bus0.in_funct3 = f_f3;   assign bus1.in_funct3 = f_f3;
  assign bus0.in_rs1 = f_rs1;     assign bus1.in_rs1 = f_rs1;
  assign bus0.in_rs2 = f_rs2;     assign bus1.in_rs2 = f_rs2;
  assign bus0.in_funct7 = f_f7;   assign bus1.in_funct7 = f_f7;
  assign bus0.in_imm = f_imm;     assign bus1.in_imm = f_imm;
  assign bus0.in_last = f_last;   assign bus1.in_last = f_last;
  assign bus0.imem_ready = mem_ready;
  assign bus1.imem_ready = mem_ready;

  instr_encoder #(.ADDR_W(10), .DEPTH(1024)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(bus0),
    .busy(busy0), .done(done0), .err(err0), .count(count0)
  );

  instr_encoder #(.ADDR_W(10), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .err(err1), .count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture accepted writes of the main instance.
  always @(posedge clk) begin
    if (bus0.imem_we && bus0.imem_ready) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus0.imem_addr;
      wr_data <= bus0.imem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Presents one bundle, waits for in_ready, returns at the negedge after the handshake edge.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [6:0] f7, input logic [31:0] imm, input logic last,
                      input bit sel);
    int n;
    logic rdy;
    @(negedge clk);
    f_fmt = fmt; f_op = op; f_rd = rd; f_f3 = f3; f_rs1 = rs1; f_rs2 = rs2;
    f_f7 = f7; f_imm = imm; f_last = last;
    if (sel) valid1 = 1'b1; else valid0 = 1'b1;
    n = 0;
    rdy = sel ? bus1.in_ready : bus0.in_ready;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
      rdy = sel ? bus1.in_ready : bus0.in_ready;
    end
    chk("in_ready_wait", 64'(rdy), 64'(1));
    @(negedge clk);
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
    f_fmt = '0; f_op = '0; f_rd = '0; f_f3 = '0; f_rs1 = '0; f_rs2 = '0;
    f_f7 = '0; f_imm = '0; f_last = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_in_ready", 64'(bus0.in_ready), 64'(0));
    chk("rst_we", 64'(bus0.imem_we), 64'(0));
    chk("rst_flags", {61'(0), busy0, done0, err0}, 64'(0));
    chk("rst_addr", 64'(bus0.imem_addr), 64'(0));
    chk("rst_wdata", 64'(bus0.imem_wdata), 64'(0));
    chk("rst_count", 64'(count0), 64'(0));
    rst_n = 1'b1;

    pulse_start(1'b0);
    chk("start_ready", 64'(bus0.in_ready), 64'(1));
    chk("start_busy", 64'(busy0), 64'(1));

    // R: add x3, x1, x2
    send(FMT_R, OP, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0, 1'b0, 1'b0);
    chk("r_we", 64'(bus0.imem_we), 64'(1));
    chk("r_addr", 64'(bus0.imem_addr), 64'(0));
    chk("r_data", 64'(bus0.imem_wdata), 64'h002081B3);
    @(negedge clk);
    chk("r_count", 64'(count0), 64'(1));

    // I: addi x5, x0, -1
    send(FMT_I, OP_IMM, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("i_addr", 64'(bus0.imem_addr), 64'(1));
    chk("i_data", 64'(bus0.imem_wdata), 64'hFFF00293);

    // S: sw x2, 8(x1)
    send(FMT_S, STORE, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8, 1'b0, 1'b0);
    chk("s_addr", 64'(bus0.imem_addr), 64'(2));
    chk("s_data", 64'(bus0.imem_wdata), 64'h0020A423);
    @(negedge clk);

    // B with backpressure: beq x1, x2, -4, last
    mem_ready = 1'b0;
    send(FMT_B, BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_we", 64'(bus0.imem_we), 64'(1));
      chk("bp_addr", 64'(bus0.imem_addr), 64'(3));
      chk("bp_data", 64'(bus0.imem_wdata), 64'hFE208EE3);
      chk("bp_in_ready", 64'(bus0.in_ready), 64'(0));
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("b_written", 64'(wr_data), 64'hFE208EE3);
    chk("b_done", 64'(done0), 64'(1));
    chk("b_err", 64'(err0), 64'(0));
    chk("b_count", 64'(count0), 64'(4));
    chk("b_busy", 64'(busy0), 64'(0));
    chk("b_writes", 64'(wr_cnt), 64'(4));

    // Illegal format ends the session without a write.
    pulse_start(1'b0);
    chk("s2_count", 64'(count0), 64'(0));
    chk("s2_addr", 64'(bus0.imem_addr), 64'(0));
    chk("s2_done", 64'(done0), 64'(0));
    send(3'd7, OP, 5'd1, 3'd0, 5'd1, 5'd1, 7'd0, 32'h0, 1'b0, 1'b0);
    chk("ill_we", 64'(bus0.imem_we), 64'(0));
    chk("ill_err", 64'(err0), 64'(1));
    chk("ill_done", 64'(done0), 64'(1));
    chk("ill_writes", 64'(wr_cnt), 64'(4));

    pulse_start(1'b0);
    chk("s3_err", 64'(err0), 64'(0));
    chk("s3_count", 64'(count0), 64'(0));
    chk("s3_addr", 64'(bus0.imem_addr), 64'(0));

    // I with imm 0x800: out of 12-bit signed range.
    send(FMT_I, OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0800, 1'b0, 1'b0);
`ifdef IMM_RANGE_CHECK_EN
    chk("rng_err", 64'(err0), 64'(1));
    chk("rng_done", 64'(done0), 64'(1));
    chk("rng_we", 64'(bus0.imem_we), 64'(0));
    chk("rng_writes", 64'(wr_cnt), 64'(4));
    pulse_start(1'b0);
`else
    chk("trunc_we", 64'(bus0.imem_we), 64'(1));
    chk("trunc_data", 64'(bus0.imem_wdata), 64'h80000013);
    @(negedge clk);
    chk("trunc_count", 64'(count0), 64'(1));
    chk("trunc_err", 64'(err0), 64'(0));
    pulse_start(1'b0);
    chk("start_ignored", 64'(count0), 64'(1));
`endif

    // Reset in the middle of a stalled write.
    mem_ready = 1'b0;
    send(FMT_R, OP, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_we", 64'(bus0.imem_we), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 64'(bus0.imem_we), 64'(0));
    chk("mid_rst_busy", 64'(busy0), 64'(0));
    chk("mid_rst_wdata", 64'(bus0.imem_wdata), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {62'(0), bus0.in_ready, busy0}, 64'(0));
    chk("post_rst_count", 64'(count0), 64'(0));

    // DEPTH=4 instance: four non-last bundles overflow the memory.
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) begin
      send(FMT_I, OP_IMM, 5'(i + 1), 3'd0, 5'd0, 5'd0, 7'd0, 32'(i), 1'b0, 1'b1);
      chk("d4_we", 64'(bus1.imem_we), 64'(1));
      chk("d4_addr", 64'(bus1.imem_addr), 64'(i));
    end
    @(negedge clk);
    chk("d4_done", 64'(done1), 64'(1));
    chk("d4_err", 64'(err1), 64'(1));
    chk("d4_in_ready", 64'(bus1.in_ready), 64'(0));
    chk("d4_count", 64'(count1), 64'(4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
